// File: rtl/mul_pkg.sv
// ============================================================================
// Module      : mul_pkg
// Description : Shared definitions for the iterative multiplier: FSM state
//               encoding, operand width, iteration counter width and the
//               magnitude helper used by the signed option.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int MUL_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // Two's-complement magnitude; the most negative value maps to its
    // unsigned magnitude 2^(MUL_WIDTH-1), which is what the multiply needs.
    function automatic logic [MUL_WIDTH-1:0] mul_abs(input logic [MUL_WIDTH-1:0] v);
        return v[MUL_WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adder32.sv
// ============================================================================
// Module      : adder32
// Description : 32-bit ripple-free behavioural adder with carry in/out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] result,
    output logic        cout
);

    // Full 33-bit sum; the top bit is the carry-out.
    assign {cout, result} = {1'b0, a} + {1'b0, b} + {32'd0, cin};

endmodule

`default_nettype wire

// File: rtl/multiply32_seq.sv
// ============================================================================
// Module      : multiply32_seq
// Description : Iterative shift-and-add 32x32 multiplier with a start/done
//               handshake. One adder32 accumulates the multiplicand into the
//               upper half of the accumulator each CALC cycle, and the
//               {carry,sum,low half} is shifted right by one.
//               Optional feature macro: SIGNED_MULT_EN (two's-complement
//               operands selected by mult_signed; sign fixed on completion).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiply32_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mult_begin,
    input  logic [WIDTH-1:0]     mult_op1,
    input  logic [WIDTH-1:0]     mult_op2,
    input  logic                 mult_signed,
    output logic                 busy,
    output logic                 mult_end,
    output logic [2*WIDTH-1:0]   product
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mul_state_t          state;
    logic [WIDTH-1:0]    mcand;
    logic [WIDTH-1:0]    acc_hi;
    logic [WIDTH-1:0]    acc_lo;
    logic [CNT_W-1:0]    cnt;

    logic [WIDTH-1:0]    add_b;
    logic [WIDTH-1:0]    add_sum;
    logic                add_cout;
    logic [2*WIDTH-1:0]  acc_next;
    logic [2*WIDTH-1:0]  product_fixed;
    logic [WIDTH-1:0]    op1_load;
    logic [WIDTH-1:0]    op2_load;

    // Add the multiplicand only when the current multiplier bit is set.
    assign add_b = acc_lo[0] ? mcand : '0;

    adder32 u_acc_add (
        .a      (acc_hi),
        .b      (add_b),
        .cin    (1'b0),
        .result (add_sum),
        .cout   (add_cout)
    );

    // The carry-out becomes the new MSB; the consumed multiplier bit drops off.
    assign acc_next = {add_cout, add_sum, acc_lo[WIDTH-1:1]};

`ifdef SIGNED_MULT_EN
    logic neg;
    logic neg_load;

    // Signed requests multiply magnitudes and remember the result sign.
    assign op1_load      = mult_signed ? mul_abs(mult_op1) : mult_op1;
    assign op2_load      = mult_signed ? mul_abs(mult_op2) : mult_op2;
    assign neg_load      = mult_signed & (mult_op1[WIDTH-1] ^ mult_op2[WIDTH-1]);
    assign product_fixed = neg ? (~acc_next + 1'b1) : acc_next;

    // Sign flag lives alongside the operands for the whole operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg <= 1'b0;
        end else if (state == IDLE && mult_begin) begin
            neg <= neg_load;
        end
    end
`else
    logic unused_signed;

    assign unused_signed = mult_signed;
    assign op1_load      = mult_op1;
    assign op2_load      = mult_op2;
    assign product_fixed = acc_next;
`endif

    // Control FSM and datapath registers; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mcand    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            mult_end <= 1'b0;
            product  <= '0;
        end else begin
            mult_end <= 1'b0;
            case (state)
                IDLE: begin
                    if (mult_begin) begin
                        mcand  <= op1_load;
                        acc_hi <= '0;
                        acc_lo <= op2_load;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    {acc_hi, acc_lo} <= acc_next;
                    cnt              <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        // Final iteration: capture the completed product directly.
                        product  <= product_fixed;
                        mult_end <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multiply32_seq.sv
// ============================================================================
// Module      : tb_multiply32_seq
// Description : Self-checking scoreboard bench for multiply32_seq. Expected
//               products are queued when a start is driven and compared when
//               mult_end pulses. Honours SIGNED_MULT_EN for expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multiply32_seq;

`ifdef SIGNED_MULT_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mult_begin;
    logic [31:0] mult_op1;
    logic [31:0] mult_op2;
    logic        mult_signed;
    logic        busy;
    logic        mult_end;
    logic [63:0] product;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];

    multiply32_seq dut (
        .clk         (clk),
        .rst         (rst),
        .mult_begin  (mult_begin),
        .mult_op1    (mult_op1),
        .mult_op2    (mult_op2),
        .mult_signed (mult_signed),
        .busy        (busy),
        .mult_end    (mult_end),
        .product     (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        if (s && SIGNED_EN) return sa * sb;
        return {32'd0, a} * {32'd0, b};
    endfunction

    // One operation: k counts negedges after the accept edge (k=0 is the
    // first CALC cycle). inj_k pulses a 2x2 start at that k; rst_k asserts
    // reset at that k. Returns first mult_end k, busy cycles and end pulses.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp, input int inj_k,
                          input int rst_k, output int end_k, output int busy_n,
                          output int end_n);
        @(negedge clk);
        mult_op1    = a;
        mult_op2    = b;
        mult_signed = s;
        mult_begin  = 1'b1;
        exp_q.push_back(exp);
        end_k  = -1;
        busy_n = 0;
        end_n  = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (mult_end) begin
                end_n++;
                if (end_k < 0) end_k = k;
                if (exp_q.size() == 0) chk({tag, "_spurious_end"}, 64'd1, 64'd0);
                else chk(tag, product, exp_q.pop_front());
            end
            if (rst_k >= 0 && k == rst_k + 1) begin
                chk({tag, "_rst_busy"}, {63'd0, busy}, 64'd0);
                chk({tag, "_rst_product"}, product, 64'd0);
                rst = 1'b0;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (k == rst_k) rst = 1'b1;
            mult_begin = (k == inj_k);
            if (k == inj_k) begin
                mult_op1 = 32'd2;
                mult_op2 = 32'd2;
            end else begin
                mult_op1 = $urandom;
                mult_op2 = $urandom;
            end
        end
        mult_begin = 1'b0;
        chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        int          e_k, b_n, e_n;
        logic [31:0] ra, rb;
        logic        rs;

        rst         = 1'b1;
        mult_begin  = 1'b0;
        mult_op1    = '0;
        mult_op2    = '0;
        mult_signed = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_end", {63'd0, mult_end}, 64'd0);
        chk("reset_product", product, 64'd0);
        rst = 1'b0;

        // Basic product, latency and busy length.
        run_op("mul_3x5", 32'd3, 32'd5, 1'b0, 64'h000000000000000F, -1, -1, e_k, b_n, e_n);
        // mult_end appears in the 34th cycle counting the accept cycle.
        chk("end_latency", 64'(e_k), 64'd32);
        chk("busy_cycles", 64'(b_n), 64'd33);
        chk("end_pulses", 64'(e_n), 64'd1);

        // Full-scale operands drive the adder carry into the shift.
        run_op("mul_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, -1, -1, e_k, b_n, e_n);
        repeat (3) @(negedge clk);
        chk("product_held", product, 64'hFFFFFFFE00000001);

        // Signed request: result depends on whether the signed option is built.
        run_op("mul_neg3x5", 32'hFFFFFFFD, 32'd5, 1'b1,
               SIGNED_EN ? 64'hFFFFFFFFFFFFFFF1 : 64'h00000004FFFFFFF1, -1, -1, e_k, b_n, e_n);
        run_op("mul_intmin", 32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, -1, -1, e_k, b_n, e_n);

        // Start while busy is ignored.
        run_op("mul_7x9", 32'd7, 32'd9, 1'b0, 64'd63, 10, -1, e_k, b_n, e_n);
        chk("busy_restart_pulses", 64'(e_n), 64'd1);
        chk("busy_restart_busy", 64'(b_n), 64'd33);

        // Start during the DONE cycle is ignored.
        run_op("mul_3x4", 32'd3, 32'd4, 1'b0, 64'd12, 32, -1, e_k, b_n, e_n);
        chk("done_restart_pulses", 64'(e_n), 64'd1);
        chk("done_restart_busy", 64'(b_n), 64'd33);

        // Reset in mid-calculation discards the result.
        run_op("mul_rst", 32'h1234, 32'h5678, 1'b0, 64'h0000000006260060, 15, 15, e_k, b_n, e_n);
        chk("rst_no_end", 64'(e_n), 64'd0);
        run_op("mul_after_rst", 32'h1234, 32'h5678, 1'b0, 64'h0000000006260060, -1, -1, e_k, b_n, e_n);

        run_op("mul_zero", 32'd0, 32'hDEADBEEF, 1'b0, 64'd0, -1, -1, e_k, b_n, e_n);

        // Random operands against the behavioural model.
        for (int i = 0; i < 1000; i++) begin
            ra = $random;
            rb = $random;
            rs = 1'({$random} % 2);
            run_op("mul_rand", ra, rb, rs, model(ra, rb, rs), -1, -1, e_k, b_n, e_n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
